tone_sequencer: RTL and testbench

Multi-channel square-wave tone generator with a per-channel note queue. It is the parametrised successor to the single-melody player used in the RickRoll project. A controller pushes {channel, period, duration} note commands over a valid/ready handshake. Each channel plays its notes back-to-back with no gap, and all channels are summed into a small mix value for a PWM/DAC stage.

---
 rtl/tone_pkg.sv | 24 ++
 rtl/tone_channel.sv | 129 ++++++++++++
 rtl/tone_sequencer.sv | 124 ++++++++++++
 tb/tb_tone_sequencer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// ---------------------------------------------------------------------------
// tone_pkg
// Shared definitions for the tone sequencer.
//   tone_state_e : per-channel state encoding (IDLE / PLAY / REST)
//   ch_width()   : width needed to address n channels (at least 1 bit)
//   mix_width()  : width needed to hold a count of 0..n active tones
// ---------------------------------------------------------------------------
package tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_REST = 2'd2
    } tone_state_e;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int mix_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tone_channel.sv
// ---------------------------------------------------------------------------
// tone_channel
// One square-wave tone voice with a single-entry pending note slot.
// Ports:
//   clock_i, reset_i  : clock, synchronous active-high reset
//   tick_i            : global duration tick (one cycle wide)
//   wr_en_i           : accepted command addressed to this channel
//   period_i          : half-period of the command (0 = rest)
//   duration_i        : length in ticks of the command (0 = null note)
//   pend_full_o       : pending slot occupied (drives cmd_ready upstream)
//   busy_o            : playing or holding a pending note
//   tone_o            : square-wave output
//   note_done_o       : one-cycle pulse after each note ends
// ---------------------------------------------------------------------------
module tone_channel
    import tone_pkg::*;
#(
    parameter int PERIOD_WIDTH = 16,
    parameter int DUR_WIDTH    = 8
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    tick_i,
    input  logic                    wr_en_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    input  logic [DUR_WIDTH-1:0]    duration_i,
    output logic                    pend_full_o,
    output logic                    busy_o,
    output logic                    tone_o,
    output logic                    note_done_o
);

    tone_state_e             state_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic [PERIOD_WIDTH-1:0] cnt_q;
    logic [DUR_WIDTH-1:0]    rem_q;
    logic                    pend_valid_q;
    logic [PERIOD_WIDTH-1:0] pend_period_q;
    logic [DUR_WIDTH-1:0]    pend_dur_q;
    logic                    tone_q;
    logic                    done_q;

    logic [PERIOD_WIDTH-1:0] ld_period;
    logic [DUR_WIDTH-1:0]    ld_dur;
    logic                    note_end;
    logic                    load_en;

    // The note to load comes from the pending slot, or straight from the
    // command bus when a command lands on an empty slot in the very cycle the
    // current note ends (keeps the hand-over gapless).
    always_comb begin
        ld_period = pend_valid_q ? pend_period_q : period_i;
        ld_dur    = pend_valid_q ? pend_dur_q    : duration_i;
        note_end  = (state_q != ST_IDLE) && tick_i && (rem_q == DUR_WIDTH'(1));
        load_en   = 1'b0;
        if (state_q == ST_IDLE) begin
            load_en = pend_valid_q;
        end else if (note_end) begin
            // A null note is not chained at note end: its own done pulse
            // would merge with the ending note's pulse. It stays pending and
            // is picked up from IDLE on the following cycle.
            load_en = (pend_valid_q || wr_en_i) && (ld_dur != '0);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            period_q      <= '0;
            cnt_q         <= '0;
            rem_q         <= '0;
            pend_valid_q  <= 1'b0;
            pend_period_q <= '0;
            pend_dur_q    <= '0;
            tone_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (wr_en_i) begin
                pend_valid_q  <= 1'b1;
                pend_period_q <= period_i;
                pend_dur_q    <= duration_i;
            end

            if (load_en) begin
                // Also consumes a same-cycle command bypassed into the load.
                pend_valid_q <= 1'b0;
                period_q     <= ld_period;
                rem_q        <= ld_dur;
                cnt_q        <= '0;
                tone_q       <= 1'b0;
                if (ld_dur == '0) begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end else if (ld_period == '0) begin
                    state_q <= ST_REST;
                end else begin
                    state_q <= ST_PLAY;
                end
                if (note_end) begin
                    done_q <= 1'b1;
                end
            end else if (note_end) begin
                state_q <= ST_IDLE;
                tone_q  <= 1'b0;
                done_q  <= 1'b1;
            end else if (state_q != ST_IDLE) begin
                if (tick_i) begin
                    rem_q <= rem_q - DUR_WIDTH'(1);
                end
                if (state_q == ST_PLAY) begin
                    if (cnt_q == period_q - PERIOD_WIDTH'(1)) begin
                        cnt_q  <= '0;
                        tone_q <= ~tone_q;
                    end else begin
                        cnt_q <= cnt_q + PERIOD_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign pend_full_o = pend_valid_q;
    assign busy_o      = (state_q != ST_IDLE) || pend_valid_q;
    assign tone_o      = tone_q;
    assign note_done_o = done_q;

endmodule

// File: rtl/tone_sequencer.sv
// ---------------------------------------------------------------------------
// tone_sequencer
// Multi-channel square-wave tone generator with a per-channel note queue.
// Ports:
//   clock, reset  : clock, synchronous active-high reset
//   cmd_valid     : note command valid
//   cmd_ready     : command accepted when cmd_valid && cmd_ready
//   cmd_channel   : target channel
//   cmd_period    : half-period in cycles (0 = rest)
//   cmd_duration  : length in ticks (0 = null note)
//   cmd_error     : one-cycle pulse after accepting an out-of-range channel
//   tone_out      : per-channel square wave
//   busy          : per-channel playing or holding a pending note
//   note_done     : per-channel one-cycle pulse at the end of each note
//   mix           : registered count of channels whose tone is high
// ---------------------------------------------------------------------------
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int  CHANNELS     = 4,
    parameter int  PERIOD_WIDTH = 16,
    parameter int  DUR_WIDTH    = 8,
    parameter int  TICK_DIV     = 1000,
    localparam int CH_WIDTH     = ch_width(CHANNELS),
    localparam int MIX_WIDTH    = mix_width(CHANNELS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CH_WIDTH-1:0]     cmd_channel,
    input  logic [PERIOD_WIDTH-1:0] cmd_period,
    input  logic [DUR_WIDTH-1:0]    cmd_duration,
    output logic                    cmd_error,
    output logic [CHANNELS-1:0]     tone_out,
    output logic [CHANNELS-1:0]     busy,
    output logic [CHANNELS-1:0]     note_done,
    output logic [MIX_WIDTH-1:0]    mix
);

    localparam int PRE_WIDTH = $clog2(TICK_DIV);

    logic [PRE_WIDTH-1:0] presc_q;
    logic                 tick;
    logic                 bad_channel;
    logic                 accept;
    logic                 cmd_error_q;
    logic [CHANNELS-1:0]  pend_full;
    logic [CHANNELS-1:0]  wr_en;
    logic [MIX_WIDTH-1:0] mix_q;
    logic [MIX_WIDTH-1:0] mix_d;

    // Free-running prescaler; every channel counts durations on this tick.
    assign tick = (presc_q == PRE_WIDTH'(TICK_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRE_WIDTH'(1);
        end
    end

    // Widened compare so non-power-of-two channel counts are caught.
    assign bad_channel = ({1'b0, cmd_channel} >= (CH_WIDTH + 1)'(CHANNELS));

    // Out-of-range commands are always taken (and dropped) so the
    // controller never stalls on them.
    always_comb begin
        cmd_ready = bad_channel;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cmd_channel == CH_WIDTH'(i)) begin
                cmd_ready = ~pend_full[i];
            end
        end
    end

    assign accept = cmd_valid && cmd_ready;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
            assign wr_en[gi] = accept && (cmd_channel == CH_WIDTH'(gi));

            tone_channel #(
                .PERIOD_WIDTH(PERIOD_WIDTH),
                .DUR_WIDTH   (DUR_WIDTH)
            ) u_channel (
                .clock_i    (clock),
                .reset_i    (reset),
                .tick_i     (tick),
                .wr_en_i    (wr_en[gi]),
                .period_i   (cmd_period),
                .duration_i (cmd_duration),
                .pend_full_o(pend_full[gi]),
                .busy_o     (busy[gi]),
                .tone_o     (tone_out[gi]),
                .note_done_o(note_done[gi])
            );
        end
    endgenerate

    always_comb begin
        mix_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mix_d = mix_d + MIX_WIDTH'(tone_out[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_error_q <= 1'b0;
            mix_q       <= '0;
        end else begin
            cmd_error_q <= accept && bad_channel;
            mix_q       <= mix_d;
        end
    end

    assign cmd_error = cmd_error_q;
    assign mix       = mix_q;

endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;

    localparam int TD = 4;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_channel;
    logic [15:0] cmd_period;
    logic [7:0]  cmd_duration;
    logic        cmd_error;
    logic [3:0]  tone_out;
    logic [3:0]  busy;
    logic [3:0]  note_done;
    logic [2:0]  mix;

    // Second instance with a non-power-of-two channel count for range errors.
    logic        cmd_valid3;
    logic        cmd_ready3;
    logic [1:0]  cmd_channel3;
    logic        cmd_error3;
    logic [2:0]  tone_out3;
    logic [2:0]  busy3;
    logic [2:0]  note_done3;
    logic [1:0]  mix3;

    int cyc      = 0;
    int rst_edge = 0;
    int checks   = 0;
    int errors   = 0;
    int exp_q[4][$];
    int mon_e;

    tone_sequencer #(
        .CHANNELS(4), .PERIOD_WIDTH(16), .DUR_WIDTH(8), .TICK_DIV(TD)
    ) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_channel(cmd_channel), .cmd_period(cmd_period), .cmd_duration(cmd_duration),
        .cmd_error(cmd_error), .tone_out(tone_out), .busy(busy),
        .note_done(note_done), .mix(mix)
    );

    tone_sequencer #(
        .CHANNELS(3), .PERIOD_WIDTH(16), .DUR_WIDTH(8), .TICK_DIV(TD)
    ) dut3 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_channel(cmd_channel3), .cmd_period(cmd_period), .cmd_duration(cmd_duration),
        .cmd_error(cmd_error3), .tone_out(tone_out3), .busy(busy3),
        .note_done(note_done3), .mix(mix3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edge counter; after edge n has occurred, cyc == n.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) rst_edge <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    // Prescaler is 0 after the last reset edge r, so ticks fall on edges
    // r+TD, r+2*TD, ...  A note loaded at edge ld ends on its d-th tick edge
    // strictly after ld; note_done is visible right after that edge.
    function automatic int done_edge(input int ld, input int d);
        int e;
        int n;
        e = ld;
        n = 0;
        while (n < d) begin
            e++;
            if (((e - rst_edge) % TD) == 0) n++;
        end
        return e;
    endfunction

    // Scoreboard: every note_done pulse must match the head expectation.
    always @(negedge clock) begin
        for (int ch = 0; ch < 4; ch++) begin
            if (note_done[ch] === 1'b1) begin
                checks++;
                if (exp_q[ch].size() == 0) begin
                    errors++;
                    $display("FAIL note_done_unexpected ch%0d: got pulse at cycle %0d, required none", ch, cyc);
                end else begin
                    mon_e = exp_q[ch].pop_front();
                    if (cyc !== mon_e) begin
                        errors++;
                        $display("FAIL note_done_time ch%0d: got cycle %0d, required cycle %0d", ch, cyc, mon_e);
                    end
                end
            end
        end
    end

    task automatic drive_cmd(input int ch, input int p, input int d);
        cmd_channel  = 2'(ch);
        cmd_period   = 16'(p);
        cmd_duration = 8'(d);
        cmd_valid    = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_channel = '0; cmd_period = '0; cmd_duration = '0;
        cmd_valid3 = 1'b0; cmd_channel3 = '0;
        repeat (3) @(negedge clock);
        checks++;
        if ({tone_out, busy, note_done, cmd_error, mix} !== 16'h0) begin
            errors++;
            $display("FAIL reset_during: got %h, required 0", {tone_out, busy, note_done, cmd_error, mix});
        end
        reset = 1'b0;
        @(negedge clock);
        #1;
        checks++;
        if ({tone_out, busy, note_done, cmd_error, mix} !== 16'h0) begin
            errors++;
            $display("FAIL reset_after: got %h, required 0", {tone_out, busy, note_done, cmd_error, mix});
        end
        checks++;
        if (cmd_ready !== 1'b1 || cmd_ready3 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b, required 1/1", cmd_ready, cmd_ready3);
        end
        $display("reset: outputs after reset release checked at cycle %0d", cyc);
    endtask

    task automatic test_basic();
        int acc, ld, e, t, prev;
        @(negedge clock);
        drive_cmd(0, 3, 2);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready: got %b, required 1", cmd_ready);
        end
        acc = cyc + 1; ld = acc + 1; e = done_edge(ld, 2);
        exp_q[0].push_back(e);
        $display("basic: ch0 {3,2} accepted at edge %0d, done expected at %0d", acc, e);
        @(negedge clock);
        cmd_valid = 1'b0;
        prev = 0;
        while (cyc <= e + 2) begin
            t = (cyc > ld && cyc < e) ? ((cyc - ld) / 3) % 2 : 0;
            checks++;
            if (tone_out !== 4'(t)) begin
                errors++;
                $display("FAIL basic_tone cycle %0d: got %b, required %b", cyc, tone_out, 4'(t));
            end
            checks++;
            if (busy[0] !== (cyc < e)) begin
                errors++;
                $display("FAIL basic_busy cycle %0d: got %b, required %b", cyc, busy[0], (cyc < e));
            end
            checks++;
            if (mix !== 3'(prev)) begin
                errors++;
                $display("FAIL basic_mix cycle %0d: got %0d, required %0d", cyc, mix, prev);
            end
            prev = t;
            @(negedge clock);
        end
        checks++;
        if (exp_q[0].size() != 0) begin
            errors++;
            $display("FAIL basic_done_missing: got %0d pending, required 0", exp_q[0].size());
        end
    endtask

    task automatic test_back_to_back();
        int acc1, l1, e1, e2, t;
        @(negedge clock);
        drive_cmd(1, 2, 1);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_first: got %b, required 1", cmd_ready);
        end
        acc1 = cyc + 1; l1 = acc1 + 1; e1 = done_edge(l1, 1);
        exp_q[1].push_back(e1);
        @(negedge clock);
        cmd_period = 16'd5;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_full: got %b, required 0", cmd_ready);
        end
        @(negedge clock);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_free: got %b, required 1", cmd_ready);
        end
        e2 = done_edge(e1, 1);
        exp_q[1].push_back(e2);
        $display("b2b: ch1 notes end at %0d and %0d", e1, e2);
        @(negedge clock);
        cmd_valid = 1'b0;
        while (cyc <= e2 + 2) begin
            if (cyc > l1 && cyc < e1)      t = ((cyc - l1) / 2) % 2;
            else if (cyc > e1 && cyc < e2) t = ((cyc - e1) / 5) % 2;
            else                           t = 0;
            checks++;
            if (tone_out[1] !== t[0]) begin
                errors++;
                $display("FAIL b2b_tone cycle %0d: got %b, required %b", cyc, tone_out[1], t[0]);
            end
            checks++;
            if (busy[1] !== (cyc < e2)) begin
                errors++;
                $display("FAIL b2b_busy cycle %0d: got %b, required %b", cyc, busy[1], (cyc < e2));
            end
            @(negedge clock);
        end
        checks++;
        if (exp_q[1].size() != 0) begin
            errors++;
            $display("FAIL b2b_done_missing: got %0d pending, required 0", exp_q[1].size());
        end
    endtask

    task automatic test_rest_null();
        int acc, ld, e;
        @(negedge clock);
        drive_cmd(2, 0, 3);
        acc = cyc + 1; ld = acc + 1; e = done_edge(ld, 3);
        exp_q[2].push_back(e);
        $display("rest: ch2 {0,3} done expected at %0d", e);
        @(negedge clock);
        cmd_valid = 1'b0;
        while (cyc <= e + 1) begin
            checks++;
            if (tone_out[2] !== 1'b0 || busy[2] !== (cyc < e)) begin
                errors++;
                $display("FAIL rest_state cycle %0d: got tone=%b busy=%b, required tone=0 busy=%b",
                         cyc, tone_out[2], busy[2], (cyc < e));
            end
            @(negedge clock);
        end
        drive_cmd(2, 7, 0);
        acc = cyc + 1;
        exp_q[2].push_back(acc + 1);
        $display("null: ch2 {7,0} done expected at %0d", acc + 1);
        @(negedge clock);
        cmd_valid = 1'b0;
        while (cyc <= acc + 5) begin
            checks++;
            if (tone_out[2] !== 1'b0 || busy[2] !== (cyc < acc + 1)) begin
                errors++;
                $display("FAIL null_state cycle %0d: got tone=%b busy=%b, required tone=0 busy=%b",
                         cyc, tone_out[2], busy[2], (cyc < acc + 1));
            end
            @(negedge clock);
        end
        checks++;
        if (exp_q[2].size() != 0) begin
            errors++;
            $display("FAIL rest_done_missing: got %0d pending, required 0", exp_q[2].size());
        end
    endtask

    task automatic test_bad_channel();
        @(negedge clock);
        cmd_channel3 = 2'd3; cmd_period = 16'd4; cmd_duration = 8'd1; cmd_valid3 = 1'b1;
        #1;
        checks++;
        if (cmd_ready3 !== 1'b1) begin
            errors++;
            $display("FAIL bad_ready: got %b, required 1", cmd_ready3);
        end
        @(negedge clock);
        cmd_valid3 = 1'b0;
        checks++;
        if (cmd_error3 !== 1'b1) begin
            errors++;
            $display("FAIL bad_error_pulse: got %b, required 1", cmd_error3);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checks++;
            if ({cmd_error3, busy3, tone_out3, note_done3} !== 10'h0) begin
                errors++;
                $display("FAIL bad_quiet cycle %0d: got %h, required 0", cyc,
                         {cmd_error3, busy3, tone_out3, note_done3});
            end
        end
        $display("bad: channel 3 on 3-channel instance dropped");
    endtask

    task automatic test_mix();
        int a, e, e2, guard, t, prev;
        logic [3:0] exp_t;
        @(negedge clock);
        guard = 0;
        while (((cyc + 2 - rst_edge) % TD) != 0 && guard < 2 * TD) begin
            @(negedge clock);
            guard++;
        end
        a = cyc + 2;
        for (int ch = 0; ch < 4; ch++) begin
            drive_cmd(ch, 0, 2);
            @(negedge clock);
        end
        e = done_edge(a, 2);
        for (int ch = 0; ch < 4; ch++) begin
            drive_cmd(ch, 1, 2);
            #1;
            checks++;
            if (cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL mix_ready ch%0d: got %b, required 1", ch, cmd_ready);
            end
            @(negedge clock);
        end
        cmd_valid = 1'b0;
        e2 = done_edge(e, 2);
        for (int ch = 0; ch < 4; ch++) begin
            exp_q[ch].push_back(e);
            exp_q[ch].push_back(e2);
        end
        $display("mix: rests end at %0d, period-1 notes end at %0d", e, e2);
        prev = 0;
        while (cyc <= e2 + 2) begin
            t = (cyc > e && cyc < e2) ? (cyc - e) % 2 : 0;
            exp_t = t[0] ? 4'hF : 4'h0;
            checks++;
            if (tone_out !== exp_t || mix !== 3'(prev)) begin
                errors++;
                $display("FAIL mix_tone cycle %0d: got tone=%h mix=%0d, required tone=%h mix=%0d",
                         cyc, tone_out, mix, exp_t, prev);
            end
            checks++;
            if (busy !== ((cyc < e2) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL mix_busy cycle %0d: got %h, required %h", cyc, busy, (cyc < e2) ? 4'hF : 4'h0);
            end
            prev = $countones(exp_t);
            @(negedge clock);
        end
        for (int ch = 0; ch < 4; ch++) begin
            checks++;
            if (exp_q[ch].size() != 0) begin
                errors++;
                $display("FAIL mix_done_missing ch%0d: got %0d pending, required 0", ch, exp_q[ch].size());
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        drive_cmd(0, 3, 5);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (busy[0] !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pre: got busy=%b ready=%b, required busy=1 ready=0", busy[0], cmd_ready);
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        #1;
        checks++;
        if ({tone_out, busy, note_done, cmd_error, mix} !== 16'h0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_after: got %h ready=%b, required 0 ready=1",
                     {tone_out, busy, note_done, cmd_error, mix}, cmd_ready);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            checks++;
            if (busy !== 4'h0 || tone_out !== 4'h0) begin
                errors++;
                $display("FAIL midreset_idle cycle %0d: got busy=%h tone=%h, required 0/0", cyc, busy, tone_out);
            end
        end
        $display("midreset: aborted note produced no further activity");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_rest_null();
        test_bad_channel();
        test_mix();
        test_reset_mid();
        for (int ch = 0; ch < 4; ch++) begin
            checks++;
            if (exp_q[ch].size() != 0) begin
                errors++;
                $display("FAIL final_queue ch%0d: got %0d pending, required 0", ch, exp_q[ch].size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
